// File: rtl/clic_irq_target.sv
// Target-side CLIC interrupt source: latches NumSrc lines, picks the highest-level
// eligible source and offers it to the core over a valid/ready + kill handshake.
module clic_irq_target #(
  parameter int unsigned NumSrc = 256,
  parameter int unsigned SrcW   = $clog2(NumSrc),
  parameter int unsigned LevelW = 8,
  parameter int unsigned PrivW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] irq_src_i,
  input  logic              cfg_we_i,
  input  logic [SrcW-1:0]   cfg_idx_i,
  input  logic              cfg_ie_i,
  input  logic              cfg_edge_i,
  input  logic [LevelW-1:0] cfg_level_i,
  input  logic [PrivW-1:0]  cfg_priv_i,
  input  logic              cfg_shv_i,
  input  logic [LevelW-1:0] threshold_i,
  output logic              irq_valid_o,
  input  logic              irq_ready_i,
  output logic [SrcW-1:0]   irq_id_o,
  output logic [LevelW-1:0] irq_level_o,
  output logic [PrivW-1:0]  irq_priv_o,
  output logic              irq_shv_o,
  output logic              kill_req_o,
  input  logic              kill_ack_i
);

  typedef enum logic [1:0] {StIdle, StOffer, StKill} state_e;

  state_e state_q, state_d;

  logic [NumSrc-1:0] ie_q, edge_q, shv_q, prev_q, epend_q, epend_d;
  logic [LevelW-1:0] level_q [NumSrc];
  logic [PrivW-1:0]  priv_q  [NumSrc];

  logic [NumSrc-1:0] pending, eligible, higher;
  logic              win_found;
  logic [SrcW-1:0]   win_id;
  logic [LevelW-1:0] win_level;
  logic              accept;

  logic [SrcW-1:0]   off_id_q, off_id_d;
  logic [LevelW-1:0] off_level_q, off_level_d;
  logic [PrivW-1:0]  off_priv_q, off_priv_d;
  logic              off_shv_q, off_shv_d;

  always_comb begin
    pending = (edge_q & epend_q) | (~edge_q & irq_src_i);
    for (int unsigned i = 0; i < NumSrc; i++) begin
      eligible[i] = pending[i] & ie_q[i] & (level_q[i] > threshold_i);
      // Preemption only counts sources other than the one on offer.
      higher[i]   = eligible[i] & (level_q[i] > off_level_q) & (SrcW'(i) != off_id_q);
    end
  end

  // Ascending scan with strict compare keeps the lowest index on level ties.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_level = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (eligible[i] && (!win_found || (level_q[i] > win_level))) begin
        win_found = 1'b1;
        win_id    = SrcW'(i);
        win_level = level_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    off_id_d    = off_id_q;
    off_level_d = off_level_q;
    off_priv_d  = off_priv_q;
    off_shv_d   = off_shv_q;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StOffer;
          off_id_d    = win_id;
          off_level_d = win_level;
          off_priv_d  = priv_q[win_id];
          off_shv_d   = shv_q[win_id];
        end
      end
      StOffer: begin
        if (irq_ready_i) begin
          accept  = 1'b1;
          state_d = StIdle;
        end else if (!eligible[off_id_q] || (|higher)) begin
          state_d = StKill;
        end
      end
      StKill: begin
        if (irq_ready_i) begin
          accept  = 1'b1;
          state_d = StIdle;
        end else if (kill_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new rising edge beats a same-cycle clear of the same id.
  always_comb begin
    epend_d = epend_q;
    if (accept) epend_d[off_id_q] = 1'b0;
    epend_d = epend_d | (edge_q & irq_src_i & ~prev_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie_q   <= '0;
      edge_q <= '0;
      shv_q  <= '0;
      for (int unsigned i = 0; i < NumSrc; i++) begin
        level_q[i] <= '0;
        priv_q[i]  <= '0;
      end
    end else if (cfg_we_i) begin
      ie_q[cfg_idx_i]    <= cfg_ie_i;
      edge_q[cfg_idx_i]  <= cfg_edge_i;
      shv_q[cfg_idx_i]   <= cfg_shv_i;
      level_q[cfg_idx_i] <= cfg_level_i;
      priv_q[cfg_idx_i]  <= cfg_priv_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      epend_q     <= '0;
      off_id_q    <= '0;
      off_level_q <= '0;
      off_priv_q  <= '0;
      off_shv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= irq_src_i;
      epend_q     <= epend_d;
      off_id_q    <= off_id_d;
      off_level_q <= off_level_d;
      off_priv_q  <= off_priv_d;
      off_shv_q   <= off_shv_d;
    end
  end

  assign irq_valid_o = (state_q != StIdle);
  assign kill_req_o  = (state_q == StKill);
  assign irq_id_o    = off_id_q;
  assign irq_level_o = off_level_q;
  assign irq_priv_o  = off_priv_q;
  assign irq_shv_o   = off_shv_q;

endmodule

// File: tb/tb_clic_irq_target.sv
// Bench for clic_irq_target: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of offer/kill/pending rules.
module tb_clic_irq_target;

  localparam int NumSrc = 256;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [255:0] irq_src_i;
  logic         cfg_we_i;
  logic [7:0]   cfg_idx_i;
  logic         cfg_ie_i;
  logic         cfg_edge_i;
  logic [7:0]   cfg_level_i;
  logic [1:0]   cfg_priv_i;
  logic         cfg_shv_i;
  logic [7:0]   threshold_i;
  logic         irq_valid_o;
  logic         irq_ready_i;
  logic [7:0]   irq_id_o;
  logic [7:0]   irq_level_o;
  logic [1:0]   irq_priv_o;
  logic         irq_shv_o;
  logic         kill_req_o;
  logic         kill_ack_i;

  clic_irq_target dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irq_src_i   (irq_src_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_ie_i    (cfg_ie_i),
    .cfg_edge_i  (cfg_edge_i),
    .cfg_level_i (cfg_level_i),
    .cfg_priv_i  (cfg_priv_i),
    .cfg_shv_i   (cfg_shv_i),
    .threshold_i (threshold_i),
    .irq_valid_o (irq_valid_o),
    .irq_ready_i (irq_ready_i),
    .irq_id_o    (irq_id_o),
    .irq_level_o (irq_level_o),
    .irq_priv_o  (irq_priv_o),
    .irq_shv_o   (irq_shv_o),
    .kill_req_o  (kill_req_o),
    .kill_ack_i  (kill_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit m_ie[NumSrc], m_edge[NumSrc], m_shv[NumSrc], m_prev[NumSrc], m_epend[NumSrc];
  int m_lvl[NumSrc], m_priv[NumSrc];
  bit m_busy, m_kill;
  int m_id, m_olvl, m_opriv, m_oshv;

  function automatic void model_reset();
    for (int i = 0; i < NumSrc; i++) begin
      m_ie[i] = 0; m_edge[i] = 0; m_shv[i] = 0; m_prev[i] = 0; m_epend[i] = 0;
      m_lvl[i] = 0; m_priv[i] = 0;
    end
    m_busy = 0; m_kill = 0;
    m_id = 0; m_olvl = 0; m_opriv = 0; m_oshv = 0;
  endfunction

  function automatic bit m_elig(int i);
    bit p;
    p = m_edge[i] ? m_epend[i] : bit'(irq_src_i[i]);
    return p && m_ie[i] && (m_lvl[i] > int'(threshold_i));
  endfunction

  function automatic int m_best();
    int cand[$];
    int top;
    top = -1;
    for (int i = 0; i < NumSrc; i++) if (m_elig(i)) cand.push_back(i);
    foreach (cand[k]) if (m_lvl[cand[k]] > top) top = m_lvl[cand[k]];
    foreach (cand[k]) if (m_lvl[cand[k]] == top) return cand[k];
    return -1;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit acc, n_busy, n_kill;
    int w;
    acc = 0; n_busy = m_busy; n_kill = m_kill;
    if (!m_busy) begin
      w = m_best();
      if (w >= 0) begin
        n_busy = 1; n_kill = 0;
        m_id = w; m_olvl = m_lvl[w]; m_opriv = m_priv[w]; m_oshv = int'(m_shv[w]);
      end
    end else if (irq_ready_i) begin
      acc = 1; n_busy = 0; n_kill = 0;
    end else if (!m_kill) begin
      bit hi;
      hi = 0;
      for (int i = 0; i < NumSrc; i++)
        if (i != m_id && m_elig(i) && m_lvl[i] > m_olvl) hi = 1;
      if (!m_elig(m_id) || hi) n_kill = 1;
    end else if (kill_ack_i) begin
      n_busy = 0; n_kill = 0;
    end
    for (int i = 0; i < NumSrc; i++) begin
      if (acc && i == m_id) m_epend[i] = 0;
      if (m_edge[i] && irq_src_i[i] && !m_prev[i]) m_epend[i] = 1;
      m_prev[i] = irq_src_i[i];
    end
    if (cfg_we_i) begin
      m_ie[cfg_idx_i]   = cfg_ie_i;
      m_edge[cfg_idx_i] = cfg_edge_i;
      m_shv[cfg_idx_i]  = cfg_shv_i;
      m_lvl[cfg_idx_i]  = int'(cfg_level_i);
      m_priv[cfg_idx_i] = int'(cfg_priv_i);
    end
    m_busy = n_busy;
    m_kill = n_kill;
  endfunction

  task automatic compare();
    check("valid", 32'(irq_valid_o), 32'(m_busy));
    check("kill_req", 32'(kill_req_o), 32'(m_kill));
    if (m_busy) begin
      check("id", 32'(irq_id_o), 32'(m_id));
      check("level", 32'(irq_level_o), 32'(m_olvl));
      check("priv", 32'(irq_priv_o), 32'(m_opriv));
      check("shv", 32'(irq_shv_o), 32'(m_oshv));
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    compare();
  endtask

  task automatic cfg(input int idx, input int ie, input int edg, input int lvl,
                     input int priv, input int shv);
    cfg_we_i = 1'b1; cfg_idx_i = 8'(idx); cfg_ie_i = 1'(ie); cfg_edge_i = 1'(edg);
    cfg_level_i = 8'(lvl); cfg_priv_i = 2'(priv); cfg_shv_i = 1'(shv);
    cycle();
    cfg_we_i = 1'b0;
  endtask

  task automatic pulse(input int idx);
    irq_src_i[idx] = 1'b1;
    cycle();
    irq_src_i[idx] = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(irq_valid_o), 32'(m_busy));
    check("rst_kill", 32'(kill_req_o), 32'(m_kill));
    check("rst_id", 32'(irq_id_o), 32'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  int subset[8] = '{0, 1, 5, 9, 10, 12, 20, 255};

  initial begin
    rst_ni = 1'b0; irq_src_i = '0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_ie_i = 1'b0;
    cfg_edge_i = 1'b0; cfg_level_i = '0; cfg_priv_i = '0; cfg_shv_i = 1'b0;
    threshold_i = '0; irq_ready_i = 1'b0; kill_ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("init_valid", 32'(irq_valid_o), 32'(0));
    check("init_kill", 32'(kill_req_o), 32'(0));
    rst_ni = 1'b1;
    compare();

    // Edge source 5: one-cycle offer latency, accept clears pending
    cfg(5, 1, 1, 3, 3, 1);
    pulse(5);
    cycle();
    check("t1_valid", 32'(irq_valid_o), 32'(1));
    check("t1_id", 32'(irq_id_o), 32'(5));
    check("t1_shv", 32'(irq_shv_o), 32'(1));
    irq_ready_i = 1'b1; cycle(); irq_ready_i = 1'b0;
    check("t1_bubble", 32'(irq_valid_o), 32'(0));
    repeat (3) cycle();
    check("t1_no_reoffer", 32'(irq_valid_o), 32'(0));

    // Level tie between 10 and 20: lowest index, re-offered after bubble
    cfg(10, 1, 0, 7, 1, 0);
    cfg(20, 1, 0, 7, 2, 0);
    irq_src_i[10] = 1'b1; irq_src_i[20] = 1'b1;
    cycle();
    check("t2_id", 32'(irq_id_o), 32'(10));
    irq_ready_i = 1'b1; cycle(); irq_ready_i = 1'b0;
    check("t2_bubble", 32'(irq_valid_o), 32'(0));
    cycle();
    check("t2_reoffer", 32'(irq_id_o), 32'(10));
    irq_src_i[10] = 1'b0; irq_src_i[20] = 1'b0;
    irq_ready_i = 1'b1; cycle(); irq_ready_i = 1'b0;
    cycle();

    // Preemption by higher-level edge source 9, resolved with kill_ack
    cfg(9, 1, 1, 9, 0, 0);
    pulse(5); cycle();
    check("t3_id5", 32'(irq_id_o), 32'(5));
    pulse(9); cycle();
    check("t3_kill", 32'(kill_req_o), 32'(1));
    kill_ack_i = 1'b1; cycle(); kill_ack_i = 1'b0;
    check("t3_dropped", 32'(irq_valid_o), 32'(0));
    cycle();
    check("t3_id9", 32'(irq_id_o), 32'(9));
    irq_ready_i = 1'b1; cycle(); irq_ready_i = 1'b0;
    cycle();
    check("t3_then5", 32'(irq_id_o), 32'(5));
    irq_ready_i = 1'b1; cycle(); irq_ready_i = 1'b0;
    cycle();

    // Ready and kill_ack together in KILL count as accept
    pulse(5); cycle();
    pulse(9); cycle();
    check("t4_kill", 32'(kill_req_o), 32'(1));
    irq_ready_i = 1'b1; kill_ack_i = 1'b1; cycle(); irq_ready_i = 1'b0; kill_ack_i = 1'b0;
    cycle();
    check("t4_next9", 32'(irq_id_o), 32'(9));
    irq_ready_i = 1'b1; cycle(); irq_ready_i = 1'b0;
    repeat (2) cycle();
    check("t4_no5", 32'(irq_valid_o), 32'(0));

    // Threshold changes kill and restore a level source
    cfg(12, 1, 0, 4, 1, 0);
    irq_src_i[12] = 1'b1; cycle();
    check("t5_id12", 32'(irq_id_o), 32'(12));
    threshold_i = 8'd4; cycle();
    check("t5_kill", 32'(kill_req_o), 32'(1));
    kill_ack_i = 1'b1; cycle(); kill_ack_i = 1'b0;
    threshold_i = 8'd3; cycle();
    check("t5_reoffer", 32'(irq_id_o), 32'(12));

    // Reset while in KILL
    threshold_i = 8'd8; cycle();
    check("t6_kill", 32'(kill_req_o), 32'(1));
    pulse(5);
    do_reset();
    irq_src_i = '1; threshold_i = '0;
    repeat (3) cycle();
    check("t6_no_offer", 32'(irq_valid_o), 32'(0));
    irq_src_i = '0;
    cfg(5, 1, 1, 3, 3, 1);
    repeat (2) cycle();

    // Random traffic on a small set of sources
    for (int n = 0; n < 3000; n++) begin
      cfg_we_i = ($urandom_range(7) == 0);
      cfg_idx_i = 8'(subset[$urandom_range(7)]);
      cfg_ie_i = ($urandom_range(3) != 0);
      cfg_edge_i = 1'($urandom);
      cfg_level_i = 8'($urandom_range(15));
      cfg_priv_i = 2'($urandom);
      cfg_shv_i = 1'($urandom);
      foreach (subset[k]) irq_src_i[subset[k]] = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) threshold_i = 8'($urandom_range(6));
      irq_ready_i = ($urandom_range(3) == 0);
      kill_ack_i = ($urandom_range(2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clic_irq_target.md
Name: clic_irq_target

Overview:
- Target-side CLIC interrupt source for CVA6 configs with RVSCLIC=1 and CLICNumInterruptSrc=256.
- Drives the core's CLIC input interface: valid/ready handshake with id, level, privilege and SHV, plus a kill request/acknowledge pair.
- Latches and arbitrates NumSrc interrupt lines against per-source configuration and a level threshold.
- Offers exactly one winner at a time and revokes an offer when it is preempted or becomes ineligible.

Parameters:
- NumSrc, 256: number of interrupt sources.
- SrcW, $clog2(NumSrc) = 8: source id width.
- LevelW, 8: interrupt level width.
- PrivW, 2: privilege mode width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- irq_src_i  in  NumSrc  raw interrupt lines, synchronous to clk_i
- cfg_we_i  in  1  per-source config write strobe
- cfg_idx_i  in  SrcW  source index written
- cfg_ie_i  in  1  enable
- cfg_edge_i  in  1  1 = rising-edge triggered, 0 = level triggered
- cfg_level_i  in  LevelW  level
- cfg_priv_i  in  PrivW  target privilege
- cfg_shv_i  in  1  selective hardware vectoring
- threshold_i  in  LevelW  minimum level; a source is eligible only if its level is strictly greater
- irq_valid_o  out  1  offer valid
- irq_ready_i  in  1  core accepts offer
- irq_id_o  out  SrcW  offered id
- irq_level_o  out  LevelW  offered level
- irq_priv_o  out  PrivW  offered privilege
- irq_shv_o  out  1  offered SHV
- kill_req_o  out  1  request to withdraw the current offer
- kill_ack_i  in  1  core confirms withdrawal

Behaviour:
- Reset, asynchronous on rst_ni low:
  - all config registers are 0, so every source has ie=0.
  - edge-pending bits, the previous-sample register and all outputs are 0.
  - FSM is in IDLE.
- Config write: cfg_we_i updates source cfg_idx_i at the clock edge. It takes effect for arbitration in the following cycle.
- Pending:
  - Edge source: pending is set when irq_src_i is 1 and the registered previous sample is 0. It stays set until an accepted handshake for that id.
  - Edge set and clear in the same cycle for the same id: set wins.
  - Level source: pending equals irq_src_i directly. A handshake does not clear it.
- Eligible = pending & ie & (level > threshold_i).
- Winner:
  - The eligible source with the highest level wins.
  - Level tie: the lowest index wins.
  - The winner is computed combinationally from the current-cycle registers.
- FSM, IDLE:
  - If any source is eligible, register the winner's id/level/priv/shv and go to OFFER. irq_valid_o rises on the next cycle, so latency is 1 cycle from eligibility to valid.
  - Otherwise stay in IDLE.
- FSM, OFFER:
  - irq_valid_o=1; id/level/priv/shv are held stable.
  - irq_ready_i=1: handshake; clear the edge-pending bit of the offered id; go to IDLE. valid is 0 for at least one cycle (mandatory bubble).
  - Else, if the offered source is no longer eligible, or another eligible source has a strictly higher level: kill_req_o=1 from the next cycle; go to KILL.
  - Ready and a kill condition in the same cycle: ready wins.
- FSM, KILL:
  - irq_valid_o stays 1 and the payload is held; kill_req_o=1.
  - irq_ready_i=1: counts as an accepted handshake (pending cleared); go to IDLE. This applies even if kill_ack_i=1 in the same cycle.
  - Else, kill_ack_i=1: drop valid and kill_req next cycle; go to IDLE; pending is untouched.
  - Neither: remain in KILL.
- Invariants:
  - kill_req_o=1 only while irq_valid_o=1.
  - Payload never changes while valid=1.
  - kill_ack_i is ignored outside KILL.
- Threshold and config changes during OFFER are evaluated like any other eligibility change.

Test Plan:
- Reset, then configure src 5 (ie=1, edge=1, level=3, priv=3, shv=1) with threshold 0. Pulse irq_src_i[5] for 1 cycle -> valid rises 1 cycle after the pending set with id=5, level=3, priv=3, shv=1. Assert ready -> valid=0 next cycle and pending[5] cleared; no re-offer.
- Level sources 10 and 20, both level=7, both asserted -> id=10 offered. Handshake, with both still asserted -> after the 1-cycle bubble id=10 is offered again.
- Offer src 5 (level 3) pending with ready=0. Assert edge src 9 (level 9) -> kill_req_o=1. kill_ack_i=1 -> valid=0. Then id=9 is offered, and src 5 is offered after src 9 is accepted.
- In KILL, assert ready and kill_ack together -> treated as accept: pending cleared, no re-offer of that id.
- Offered level src 12 at level 4. Raise threshold_i to 4 -> kill. Lower threshold_i to 3 -> src 12 re-offered.
- Assert rst_ni low while in KILL -> valid, kill_req and all pending bits are 0 immediately. After reset, irq_src_i held high produces no offer because ie=0.
